// File: rtl/blk_scan_rd_gen_if.sv
// Read-side bus of the block-scan read-address generator: strobe, address and per-pixel tags.
interface blk_scan_rd_gen_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned ZONE_W = 9
) ();
  logic              o_rd_en;
  logic [ADDR_W-1:0] o_rd_addr;
  logic [3:0]        o_pix_col;
  logic [5:0]        o_pix_row;
  logic [ZONE_W-1:0] o_zone;
  logic              o_blk_first;
  logic              o_blk_last;
  logic              o_band_done;
  logic              o_busy;
  logic              o_overrun;

  modport master (
    output o_rd_en, o_rd_addr, o_pix_col, o_pix_row, o_zone,
           o_blk_first, o_blk_last, o_band_done, o_busy, o_overrun
  );

  modport slave (
    input  o_rd_en, o_rd_addr, o_pix_col, o_pix_row, o_zone,
           o_blk_first, o_blk_last, o_band_done, o_busy, o_overrun
  );
endinterface

// File: rtl/blk_scan_rd_gen.sv
// Block-scan read-address generator for the ping-pong line-band frame buffer.
// Each page_sel edge starts one band read zone by zone, row by row, paced by i_slot.
module blk_scan_rd_gen #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned BLK_W      = 9,
  parameter int unsigned BLK_H      = 53,
  parameter int unsigned BLKS_X     = 24,
  parameter int unsigned BLKS_Y     = 15,
  parameter int unsigned ZONE_W     = 9,
  parameter int unsigned PAGE0_BASE = 1,
  parameter int unsigned PAGE1_BASE = 11449
) (
  input  logic              i_pix_clk,
  input  logic              rst_n,
  input  logic              page_sel,
  input  logic              i_slot,
  input  logic              i_hold,
  input  logic              i_frame_start,
  blk_scan_rd_gen_if.master rd
);

  localparam int unsigned LINE   = BLK_W * BLKS_X;
  localparam int unsigned BX_W   = (BLKS_X > 1) ? $clog2(BLKS_X) : 1;
  localparam int unsigned BAND_W = (BLKS_Y > 1) ? $clog2(BLKS_Y) : 1;

  // Incremental address steps: next row of the same zone, and back up to the next zone's top-left.
  localparam logic [ADDR_W-1:0] STEP_ROW  = ADDR_W'(LINE - BLK_W + 1);
  localparam logic [ADDR_W-1:0] STEP_ZONE = ADDR_W'(LINE * (BLK_H - 1) - 1);
  localparam logic [ADDR_W-1:0] BASE0     = ADDR_W'(PAGE0_BASE);
  localparam logic [ADDR_W-1:0] BASE1     = ADDR_W'(PAGE1_BASE);
  localparam logic [3:0]        COL_LAST  = 4'(BLK_W - 1);
  localparam logic [5:0]        ROW_LAST  = 6'(BLK_H - 1);
  localparam logic [BX_W-1:0]   BX_LAST   = BX_W'(BLKS_X - 1);
  localparam logic [BAND_W-1:0] BAND_LAST = BAND_W'(BLKS_Y - 1);

  // ST_DRAIN keeps busy high for the cycle that carries the last read strobe.
  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DRAIN} state_e;

  state_e              state_q, state_d;
  logic                ps_meta_q, ps_sync_q, ps_prev_q;
  logic [3:0]          col_q, col_d;
  logic [5:0]          row_q, row_d;
  logic [BX_W-1:0]     bx_q, bx_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ZONE_W-1:0]   zone_cnt_q, zone_cnt_d;
  logic [BAND_W-1:0]   band_nxt_q, band_nxt_d;
  logic [BAND_W-1:0]   band_sel;

  logic                rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [3:0]          pix_col_q, pix_col_d;
  logic [5:0]          pix_row_q, pix_row_d;
  logic [ZONE_W-1:0]   zone_q, zone_d;
  logic                blk_first_q, blk_first_d;
  logic                blk_last_q, blk_last_d;
  logic                band_done_q, band_done_d;
  logic                busy_q, busy_d;
  logic                overrun_q, overrun_d;

  logic start_c, issue_c, col_end_c, row_end_c, bx_end_c, final_c;

  assign start_c   = ps_sync_q ^ ps_prev_q;
  assign issue_c   = (state_q == ST_SCAN) && i_slot && !i_hold;
  assign col_end_c = (col_q == COL_LAST);
  assign row_end_c = (row_q == ROW_LAST);
  assign bx_end_c  = (bx_q == BX_LAST);
  assign final_c   = issue_c && col_end_c && row_end_c && bx_end_c;

  // State, counters, page_sel synchroniser and output registers.
  always_ff @(posedge i_pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ps_meta_q   <= 1'b0;
      ps_sync_q   <= 1'b0;
      ps_prev_q   <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
      bx_q        <= '0;
      addr_q      <= '0;
      zone_cnt_q  <= '0;
      band_nxt_q  <= '0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      pix_col_q   <= '0;
      pix_row_q   <= '0;
      zone_q      <= '0;
      blk_first_q <= 1'b0;
      blk_last_q  <= 1'b0;
      band_done_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ps_meta_q   <= page_sel;
      ps_sync_q   <= ps_meta_q;
      ps_prev_q   <= ps_sync_q;
      col_q       <= col_d;
      row_q       <= row_d;
      bx_q        <= bx_d;
      addr_q      <= addr_d;
      zone_cnt_q  <= zone_cnt_d;
      band_nxt_q  <= band_nxt_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      pix_col_q   <= pix_col_d;
      pix_row_q   <= pix_row_d;
      zone_q      <= zone_d;
      blk_first_q <= blk_first_d;
      blk_last_q  <= blk_last_d;
      band_done_q <= band_done_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

  // Next state: issue/advance the scan, finish the band, or (re)start on a page edge.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    bx_d        = bx_q;
    addr_d      = addr_q;
    zone_cnt_d  = zone_cnt_q;
    band_nxt_d  = band_nxt_q;
    rd_en_d     = 1'b0;
    rd_addr_d   = rd_addr_q;
    pix_col_d   = pix_col_q;
    pix_row_d   = pix_row_q;
    zone_d      = zone_q;
    blk_first_d = blk_first_q;
    blk_last_d  = blk_last_q;
    band_done_d = 1'b0;
    busy_d      = busy_q;
    overrun_d   = 1'b0;
    band_sel    = i_frame_start ? '0 : band_nxt_q;

    if (i_frame_start) begin
      band_nxt_d = '0;
    end

    if (issue_c) begin
      rd_en_d     = 1'b1;
      rd_addr_d   = addr_q;
      pix_col_d   = col_q;
      pix_row_d   = row_q;
      zone_d      = zone_cnt_q;
      blk_first_d = (col_q == 4'd0) && (row_q == 6'd0);
      blk_last_d  = col_end_c && row_end_c;
      if (!col_end_c) begin
        col_d  = col_q + 4'd1;
        addr_d = addr_q + ADDR_W'(1);
      end else if (!row_end_c) begin
        col_d  = '0;
        row_d  = row_q + 6'd1;
        addr_d = addr_q + STEP_ROW;
      end else begin
        col_d      = '0;
        row_d      = '0;
        bx_d       = bx_q + BX_W'(1);
        zone_cnt_d = zone_cnt_q + ZONE_W'(1);
        addr_d     = addr_q - STEP_ZONE;
      end
      if (final_c) begin
        state_d = ST_DRAIN;
      end
    end

    if (state_q == ST_DRAIN) begin
      state_d     = ST_IDLE;
      busy_d      = 1'b0;
      band_done_d = 1'b1;
    end

    // A page edge always wins; an unfinished band is aborted and flagged.
    if (start_c) begin
      overrun_d  = (state_q == ST_SCAN) && !final_c;
      state_d    = ST_SCAN;
      busy_d     = 1'b1;
      col_d      = '0;
      row_d      = '0;
      bx_d       = '0;
      addr_d     = ps_sync_q ? BASE0 : BASE1;
      zone_cnt_d = ZONE_W'(32'(band_sel) * BLKS_X);
      band_nxt_d = (band_sel == BAND_LAST) ? '0 : band_sel + BAND_W'(1);
    end
  end

  assign rd.o_rd_en     = rd_en_q;
  assign rd.o_rd_addr   = rd_addr_q;
  assign rd.o_pix_col   = pix_col_q;
  assign rd.o_pix_row   = pix_row_q;
  assign rd.o_zone      = zone_q;
  assign rd.o_blk_first = blk_first_q;
  assign rd.o_blk_last  = blk_last_q;
  assign rd.o_band_done = band_done_q;
  assign rd.o_busy      = busy_q;
  assign rd.o_overrun   = overrun_q;

endmodule
